// File: rtl/cordic_polar_to_rect_if.sv
`default_nettype none
// ============================================================================
// Module      : cordic_polar_to_rect_if
// Description : Start/done handshake and data bus for the polar-to-rect CORDIC.
// Revision    : 1.0 - initial release
// ============================================================================
interface cordic_polar_to_rect_if #(
    parameter int W = 16
);
    logic                  start;
    logic signed [W-1:0]   mag;
    logic signed [W-1:0]   angle;
    logic                  busy;
    logic                  done;
    logic signed [W+1:0]   x_out;
    logic signed [W+1:0]   y_out;

    modport master (output start, mag, angle, input busy, done, x_out, y_out);
    modport slave  (input start, mag, angle, output busy, done, x_out, y_out);
endinterface
`default_nettype wire

// File: rtl/cordic_polar_to_rect.sv
`default_nettype none
// ============================================================================
// Module      : cordic_polar_to_rect
// Description : Iterative rotation-mode CORDIC, (mag, angle) -> (r*cos, r*sin),
//               one micro-rotation per clock. Optional macro
//               CORDIC_GAIN_COMP_EN pre-scales x0 by K to remove CORDIC gain.
// Revision    : 1.0 - initial release
// ============================================================================
module cordic_polar_to_rect #(
    parameter int W    = 16,
    parameter int ITER = 16
) (
    input  wire logic              clk,
    input  wire logic              rst_n,
    cordic_polar_to_rect_if.slave  bus
);
    localparam int XW = W + 4;
    localparam int ZW = W + 1;
    localparam int OW = W + 2;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_ITER = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    localparam logic signed [ZW-1:0] c_HALF_PI = ZW'(12868);
    localparam logic signed [ZW-1:0] c_PI      = ZW'(25736);
    localparam logic [3:0]           c_LAST    = 4'(ITER - 1);

    logic [1:0]              r_state;
    logic [3:0]              r_iter;
    logic signed [XW-1:0]    r_x, r_y;
    logic signed [ZW-1:0]    r_z;
    logic                    r_busy, r_done;
    logic signed [OW-1:0]    r_x_out, r_y_out;

    logic signed [ZW-1:0]    w_angle_ext, w_z0, w_atan, w_z_nx;
    logic signed [XW-1:0]    w_mag_ext, w_x_fold, w_x0;
    logic signed [XW-1:0]    w_xs, w_ys, w_x_nx, w_y_nx;
    logic                    w_neg;

    assign w_angle_ext = {bus.angle[W-1], bus.angle};
    assign w_mag_ext   = {{4{bus.mag[W-1]}}, bus.mag};

    // Fold angles beyond +/-pi/2 into range by rotating the start vector by pi.
    always_comb begin
        w_z0     = w_angle_ext;
        w_x_fold = w_mag_ext;
        if (w_angle_ext > c_HALF_PI) begin
            w_z0     = w_angle_ext - c_PI;
            w_x_fold = -w_mag_ext;
        end else if (w_angle_ext < -c_HALF_PI) begin
            w_z0     = w_angle_ext + c_PI;
            w_x_fold = -w_mag_ext;
        end
    end

`ifdef CORDIC_GAIN_COMP_EN
    localparam int PW = XW + 15;
    localparam logic signed [PW-1:0] c_K = PW'(9949);
    logic signed [PW-1:0] w_prod;
    assign w_prod = PW'(w_x_fold) * c_K;
    assign w_x0   = XW'(w_prod >>> 14);
`else
    assign w_x0   = w_x_fold;
`endif

    always_comb begin
        w_atan = '0;
        case (r_iter)
            4'd0:  w_atan = ZW'(6434);
            4'd1:  w_atan = ZW'(3798);
            4'd2:  w_atan = ZW'(2007);
            4'd3:  w_atan = ZW'(1019);
            4'd4:  w_atan = ZW'(511);
            4'd5:  w_atan = ZW'(256);
            4'd6:  w_atan = ZW'(128);
            4'd7:  w_atan = ZW'(64);
            4'd8:  w_atan = ZW'(32);
            4'd9:  w_atan = ZW'(16);
            4'd10: w_atan = ZW'(8);
            4'd11: w_atan = ZW'(4);
            4'd12: w_atan = ZW'(2);
            4'd13: w_atan = ZW'(1);
            4'd14: w_atan = ZW'(1);
            4'd15: w_atan = ZW'(0);
            default: w_atan = '0;
        endcase
    end

    assign w_xs   = r_x >>> r_iter;
    assign w_ys   = r_y >>> r_iter;
    assign w_neg  = r_z[ZW-1];
    assign w_x_nx = w_neg ? (r_x + w_ys) : (r_x - w_ys);
    assign w_y_nx = w_neg ? (r_y - w_xs) : (r_y + w_xs);
    assign w_z_nx = w_neg ? (r_z + w_atan) : (r_z - w_atan);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
            r_iter  <= '0;
            r_x     <= '0;
            r_y     <= '0;
            r_z     <= '0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_x_out <= '0;
            r_y_out <= '0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (bus.start) begin
                        r_x     <= w_x0;
                        r_y     <= '0;
                        r_z     <= w_z0;
                        r_iter  <= '0;
                        r_busy  <= 1'b1;
                        r_state <= S_ITER;
                    end
                end
                S_ITER: begin
                    r_x <= w_x_nx;
                    r_y <= w_y_nx;
                    r_z <= w_z_nx;
                    if (r_iter == c_LAST) begin
                        r_busy  <= 1'b0;
                        r_state <= S_DONE;
                    end else begin
                        r_iter <= r_iter + 4'd1;
                    end
                end
                S_DONE: begin
                    r_done  <= 1'b1;
                    r_x_out <= OW'(r_x);
                    r_y_out <= OW'(r_y);
                    r_state <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign bus.busy  = r_busy;
    assign bus.done  = r_done;
    assign bus.x_out = r_x_out;
    assign bus.y_out = r_y_out;
endmodule
`default_nettype wire
